hls_run_sched: RTL and testbench
================================

HLS_RUN_SCHED -- requirements
Module: hls_run_sched

Interface
REQ-001 Parameter CYCLE_W, default 32: width of cycle counter and res_cycles.
REQ-002 Parameter TIMEOUT, default 200000000: max cycles per run before the run is declared hung; legal range 1 to 2^CYCLE_W-1.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  host requests a batch of runs.
REQ-006 cmd_ready  output  1  high only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
REQ-007 cmd_runs  input  8  number of back-to-back runs; 0 treated as 1.
REQ-008 abort  input  1  cancel the current run and the rest of the batch.
REQ-009 start_port  output  1  one-cycle start pulse to the accelerator.
REQ-010 done_port  input  1  accelerator completion, sampled every cycle.
REQ-011 res_valid  output  1  per-run result available.
REQ-012 res_ready  input  1  result consumer handshake.
REQ-013 res_cycles  output  CYCLE_W  cycles taken by the reported run.
REQ-014 res_status  output  2  00 ok, 01 timeout, 10 aborted, 11 unused.
REQ-015 res_index  output  8  zero-based run index within the batch.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, START, WAIT, REPORT; no other reachable states.
REQ-018 IDLE: on cmd accept, latch remaining = max(cmd_runs,1), clear index, go to START.
REQ-019 START: start_port=1 for exactly this cycle; counter loads 1; next state WAIT, or REPORT if done_port or abort is high this cycle.
REQ-020 WAIT: counter increments by 1 per cycle, saturating at 2^CYCLE_W-1.
REQ-021 res_cycles = cycles from the start_port cycle through the done_port cycle inclusive; done in the START cycle gives 1, done on the next cycle gives 2.
REQ-022 WAIT with done_port=1: go to REPORT, status 00.
REQ-023 WAIT with counter==TIMEOUT and done_port=0: go to REPORT, status 01, res_cycles=TIMEOUT.
REQ-024 Priority in the same cycle: done_port > abort > timeout.
REQ-025 abort in START or WAIT (no done_port): go to REPORT, status 10, res_cycles = current count; abort in IDLE or REPORT is ignored.
REQ-026 REPORT: res_valid=1 with res_cycles, res_status, res_index held stable until res_ready=1; all three outputs are registered.
REQ-027 On the REPORT handshake: decrement remaining; if status 00 and remaining>0, increment index and go to START on the next cycle; otherwise go to IDLE.
REQ-028 A status 01 or 10 terminates the batch; the remaining runs produce no result.
REQ-029 Exactly one result is produced per started run; start_port never asserts outside START.
REQ-030 done_port high in IDLE or REPORT is ignored and never produces a result.
REQ-031 cmd_valid outside IDLE is not accepted and is not queued.

Reset
REQ-032 Reset has priority over all inputs; the next state is IDLE.
REQ-033 Reset values: start_port=0, res_valid=0, res_cycles=0, res_status=00, res_index=0, busy=0, cmd_ready=1 on the first cycle after reset release.
REQ-034 Reset mid-run discards the batch and produces no result; the accelerator is not re-pulsed.

Verification
REQ-035 cmd_runs=1; done_port rises 5 cycles after start_port (cycle 6) -> one result: res_cycles=6, status 00, index 0; busy falls after the handshake.
REQ-036 cmd_runs=3; done each run after 3 cycles; res_ready held high -> three results, indices 0,1,2, res_cycles=3 each, exactly three start_port pulses.
REQ-037 TIMEOUT=10; done never asserted -> result res_cycles=10, status 01; batch of 4 ends after 1 result.
REQ-038 done_port high in the START cycle -> res_cycles=1, status 00; done_port and abort together in WAIT -> status 00.
REQ-039 abort on the 4th WAIT cycle -> status 10, res_cycles=5; res_ready held low 7 cycles -> outputs stable throughout; then IDLE.
REQ-040 Reset asserted in WAIT; done_port arrives afterwards -> no res_valid, all outputs at reset values, cmd_ready=1.

Source files
------------

// File: rtl/hls_run_sched.sv
// hls_run_sched: issues a batch of back-to-back accelerator runs, times each
// one, and reports one result per started run (ok / timeout / aborted).
// Any timeout or abort ends the batch early.
module hls_run_sched #(
    parameter int          CYCLE_W = 32,
    parameter int unsigned TIMEOUT = 32'd200000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_runs,
    input  logic               abort,
    output logic               start_port,
    input  logic               done_port,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CYCLE_W-1:0] res_cycles,
    output logic [1:0]         res_status,
    output logic [7:0]         res_index,
    output logic               busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] START  = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;

    localparam logic [CYCLE_W-1:0] CNT_ONE   = {{(CYCLE_W-1){1'b0}}, 1'b1};
    localparam logic [CYCLE_W-1:0] CNT_MAX   = {CYCLE_W{1'b1}};
    localparam logic [CYCLE_W-1:0] TIMEOUT_C = CYCLE_W'(TIMEOUT);

    logic [1:0]         state_r;
    logic [7:0]         remaining_r;
    logic [7:0]         index_r;
    logic [CYCLE_W-1:0] count_r;
    logic               start_port_r;
    logic               cmd_ready_r;
    logic               busy_r;
    logic               res_valid_r;
    logic [CYCLE_W-1:0] res_cycles_r;
    logic [1:0]         res_status_r;
    logic [7:0]         res_index_r;

    logic [1:0]         next_s;
    logic               fin_s;
    logic [1:0]         fin_status_s;
    logic [CYCLE_W-1:0] fin_cycles_s;
    logic [CYCLE_W-1:0] cur_s;

    // Next-state and run-completion decode; cur_s is the cycle count that
    // includes the present cycle (count_r holds the count up to the previous one).
    always_comb begin
        next_s       = state_r;
        fin_s        = 1'b0;
        fin_status_s = ST_OK;
        fin_cycles_s = count_r;
        if (count_r == CNT_MAX) begin
            cur_s = CNT_MAX;
        end else begin
            cur_s = count_r + CNT_ONE;
        end
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    next_s = START;
                end else begin
                    next_s = IDLE;
                end
            end
            START: begin
                if (done_port) begin
                    fin_s        = 1'b1;
                    fin_status_s = ST_OK;
                    fin_cycles_s = CNT_ONE;
                end else if (abort) begin
                    fin_s        = 1'b1;
                    fin_status_s = ST_ABORT;
                    fin_cycles_s = CNT_ONE;
                end else begin
                    next_s = WAIT;
                end
            end
            WAIT: begin
                if (done_port) begin
                    fin_s        = 1'b1;
                    fin_status_s = ST_OK;
                    fin_cycles_s = cur_s;
                end else if (abort) begin
                    fin_s        = 1'b1;
                    fin_status_s = ST_ABORT;
                    fin_cycles_s = cur_s;
                end else if (cur_s >= TIMEOUT_C) begin
                    fin_s        = 1'b1;
                    fin_status_s = ST_TIMEOUT;
                    fin_cycles_s = TIMEOUT_C;
                end else begin
                    next_s = WAIT;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    if ((res_status_r == ST_OK) && (remaining_r > 8'd1)) begin
                        next_s = START;
                    end else begin
                        next_s = IDLE;
                    end
                end else begin
                    next_s = REPORT;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
        if (fin_s) begin
            next_s = REPORT;
        end else begin
            next_s = next_s;
        end
    end

    // State, batch bookkeeping and registered outputs derived from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            remaining_r  <= 8'd0;
            index_r      <= 8'd0;
            count_r      <= {CYCLE_W{1'b0}};
            start_port_r <= 1'b0;
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            res_valid_r  <= 1'b0;
            res_cycles_r <= {CYCLE_W{1'b0}};
            res_status_r <= 2'b00;
            res_index_r  <= 8'd0;
        end else begin
            state_r      <= next_s;
            start_port_r <= (next_s == START);
            cmd_ready_r  <= (next_s == IDLE);
            busy_r       <= (next_s != IDLE);
            res_valid_r  <= (next_s == REPORT);
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        remaining_r <= (cmd_runs == 8'd0) ? 8'd1 : cmd_runs;
                        index_r     <= 8'd0;
                    end
                end
                START: begin
                    count_r <= CNT_ONE;
                end
                WAIT: begin
                    count_r <= cur_s;
                end
                REPORT: begin
                    if (res_ready) begin
                        remaining_r <= remaining_r - 8'd1;
                        if (next_s == START) begin
                            index_r <= index_r + 8'd1;
                        end
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
            if (fin_s) begin
                res_cycles_r <= fin_cycles_s;
                res_status_r <= fin_status_s;
                res_index_r  <= index_r;
            end
        end
    end

    assign start_port = start_port_r;
    assign cmd_ready  = cmd_ready_r;
    assign busy       = busy_r;
    assign res_valid  = res_valid_r;
    assign res_cycles = res_cycles_r;
    assign res_status = res_status_r;
    assign res_index  = res_index_r;

endmodule

// File: tb/tb_hls_run_sched.sv
// Self-checking bench for hls_run_sched: directed and random batches compared
// against a per-run outcome model (first of done / abort / timeout).
module tb_hls_run_sched;

    localparam int TO = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_runs = 8'd0;
    logic        abort = 1'b0;
    logic        start_port;
    logic        done_port = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_cycles;
    logic [1:0]  res_status;
    logic [7:0]  res_index;
    logic        busy;

    int passed = 0;
    int total  = 0;
    int done_at [0:15];
    int abort_at[0:15];

    hls_run_sched #(.CYCLE_W(32), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_runs(cmd_runs), .abort(abort), .start_port(start_port),
        .done_port(done_port), .res_valid(res_valid), .res_ready(res_ready),
        .res_cycles(res_cycles), .res_status(res_status), .res_index(res_index),
        .busy(busy)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Outcome of run r: the earliest cycle with done (wins), abort, or the timeout limit.
    function automatic void model_run(input int r, output logic [1:0] st, output int cyc);
        bit found = 1'b0;
        st = 2'b01;
        cyc = TO;
        for (int t = 1; t <= TO && !found; t++) begin
            if (done_at[r] == t) begin st = 2'b00; cyc = t; found = 1'b1; end
            else if (abort_at[r] == t) begin st = 2'b10; cyc = t; found = 1'b1; end
            else if (t == TO) begin st = 2'b01; cyc = TO; found = 1'b1; end
        end
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_start"}, {31'd0, start_port}, 32'd0);
    endtask

    task automatic idle_junk(input int n);
        for (int i = 0; i < n; i++) begin
            done_port = 1'($urandom_range(0, 1));
            abort     = 1'($urandom_range(0, 1));
            @(negedge clock);
            check_idle("idle_junk");
        end
        done_port = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic drive_run(input int r, input int t, input bit junk_cmd);
        done_port = (done_at[r] == t);
        abort     = (abort_at[r] == t);
        cmd_valid = junk_cmd ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_runs  = 8'($urandom_range(0, 255));
    endtask

    task automatic do_batch(input int runs8, input int rdy_wait, input bit junk_cmd);
        int nruns;
        int t;
        int ec;
        logic [1:0] es;
        nruns = (runs8 == 0) ? 1 : runs8;
        @(negedge clock);
        chk("cmd_ready_before", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_runs  = 8'(runs8);
        @(negedge clock);
        cmd_valid = 1'b0;
        for (int r = 0; r < nruns; r++) begin
            model_run(r, es, ec);
            chk("start_pulse", {31'd0, start_port}, 32'd1);
            t = 1;
            drive_run(r, t, junk_cmd);
            forever begin
                @(negedge clock);
                if (res_valid) break;
                t++;
                if (t > TO + 5) begin
                    chk("run_hang", 32'd0, 32'd1);
                    $fatal(1, "FAIL run_hang: no result after %0d cycles", t);
                end
                chk("start_only_once", {31'd0, start_port}, 32'd0);
                drive_run(r, t, junk_cmd);
            end
            chk("busy_report", {31'd0, busy}, 32'd1);
            chk("cmd_ready_report", {31'd0, cmd_ready}, 32'd0);
            for (int w = 0; w <= rdy_wait; w++) begin
                if (w > 0) @(negedge clock);
                chk("res_valid", {31'd0, res_valid}, 32'd1);
                chk("res_cycles", res_cycles, 32'(ec));
                chk("res_status", {30'd0, res_status}, {30'd0, es});
                chk("res_index", {24'd0, res_index}, 32'(r));
                done_port = 1'($urandom_range(0, 1));
                abort     = 1'($urandom_range(0, 1));
                cmd_valid = junk_cmd ? 1'($urandom_range(0, 1)) : 1'b0;
                res_ready = (w == rdy_wait);
            end
            @(negedge clock);
            res_ready = 1'b0;
            cmd_valid = 1'b0;
            done_port = 1'b0;
            abort     = 1'b0;
            if (es == 2'b00 && r < nruns - 1) begin
                continue;
            end else begin
                check_idle("batch_end");
                break;
            end
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 16; i++) begin
            done_at[i]  = 0;
            abort_at[i] = 0;
        end
    endtask

    initial begin
        clear_plan();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_idle("reset");
        chk("reset_res_cycles", res_cycles, 32'd0);
        chk("reset_res_status", {30'd0, res_status}, 32'd0);
        chk("reset_res_index", {24'd0, res_index}, 32'd0);
        idle_junk(3);

        // single run, done on cycle 6
        clear_plan(); done_at[0] = 6;
        do_batch(1, 0, 1'b0);
        // three runs of 3 cycles each, consumer always ready
        clear_plan(); for (int i = 0; i < 3; i++) done_at[i] = 3;
        do_batch(3, 0, 1'b0);
        // timeout ends a batch of four after the first result
        clear_plan();
        do_batch(4, 1, 1'b0);
        idle_junk(2);
        // done in the START cycle; then done together with abort in WAIT
        clear_plan(); done_at[0] = 1; done_at[1] = 4; abort_at[1] = 4;
        do_batch(2, 0, 1'b0);
        // abort on the 4th WAIT cycle, consumer stalls 7 cycles
        clear_plan(); abort_at[0] = 5;
        do_batch(2, 7, 1'b0);
        // abort in START, abort racing the timeout
        clear_plan(); abort_at[0] = 1;
        do_batch(1, 0, 1'b0);
        clear_plan(); abort_at[0] = TO;
        do_batch(1, 0, 1'b0);
        // zero run count behaves as one run
        clear_plan(); done_at[0] = 2; done_at[1] = 2;
        do_batch(0, 0, 1'b0);
        idle_junk(2);

        // random batches with stray commands during the run
        for (int b = 0; b < 8; b++) begin
            clear_plan();
            for (int i = 0; i < 6; i++) begin
                done_at[i]  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
                abort_at[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0;
            end
            do_batch(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 1'b1);
            idle_junk(1);
        end

        // reset in the middle of a run, done arrives afterwards
        clear_plan();
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_runs  = 8'd2;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("mid_run_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        done_port = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_idle("post_reset");
            chk("post_reset_cycles", res_cycles, 32'd0);
            chk("post_reset_status", {30'd0, res_status}, 32'd0);
            chk("post_reset_index", {24'd0, res_index}, 32'd0);
        end
        done_port = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
